// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch with PC-tagged buffer and redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pcplus4,
  input  logic        if_ready
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [AW-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [31:0]   tag_q [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic          rsp, fire, pop, keep;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  // Slots are allocated at request time (tag) and filled in order on response,
  // so the tag FIFO and instruction buffer share one circular index space.
  assign rsp            = imem_rsp_valid && out_q != '0;
  assign fire           = imem_req_valid && imem_req_ready;
  assign pop            = if_valid && if_ready && !redirect_valid;
  assign keep           = rsp && !redirect_valid && disc_q == '0;
  assign imem_req_valid = reset && !redirect_valid &&
                          (({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign if_valid       = cnt_q != '0;
  assign if_pc          = tag_q[head_q];
  assign if_instr       = instr_q[head_q];
  assign if_pcplus4     = tag_q[head_q] + 32'd4;
  // Next-state: redirect flushes the buffer and turns the remaining in-flight count into discards
  always_comb begin
    pc_d   = redirect_valid ? {redirect_pc[31:2], 2'b00} : fire ? pc_q + 32'd4 : pc_q;
    out_d  = out_q - CW'(rsp) + CW'(fire);
    disc_d = redirect_valid ? out_q - CW'(rsp) : (rsp && disc_q != '0) ? disc_q - CW'(1) : disc_q;
    cnt_d  = redirect_valid ? '0 : cnt_q + CW'(keep) - CW'(pop);
    head_d = redirect_valid ? '0 : pop  ? nxt(head_q) : head_q;
    fill_d = redirect_valid ? '0 : keep ? nxt(fill_q) : fill_q;
    tail_d = redirect_valid ? '0 : fire ? nxt(tail_q) : tail_q;
  end
  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      disc_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
    end
  end
  // Data storage: tag written on accepted request, instruction on kept response
  always_ff @(posedge clk) begin
    if (fire) tag_q[tail_q] <= pc_q;
    if (keep) instr_q[fill_q] <= imem_rsp_data;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench against a queue-based reference model
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h00000000;
  logic        clk = 0;
  logic        reset, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        if_valid, if_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, if_pc, if_instr, if_pcplus4;
  int          n_vec = 0, n_bad = 0, cyc = 0;
  int          pr = 100, pif = 100, prsp = 100, xlat = 0;
  bit          chk_en = 0;
  logic [31:0] m_pc;
  int          m_out = 0, m_disc = 0;
  logic [31:0] m_tags[$], m_bpc[$], m_bins[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_pcplus4(if_pcplus4),
    .if_ready(if_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h01234567;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input bit rn, input bit rd, input logic [31:0] rp);
    bit exp_req, rsp, pop, fire;
    reset = rn;
    redirect_valid = rd;
    redirect_pc = rp;
    imem_req_ready = ($urandom % 100) < pr;
    if_ready = ($urandom % 100) < pif;
    imem_rsp_data = $urandom;
    imem_rsp_valid = 0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc && ($urandom % 100) < prsp) begin
      imem_rsp_valid = 1;
      imem_rsp_data = word(mq_addr[0]);
    end else if (mq_addr.size() == 0 && $urandom % 25 == 0) imem_rsp_valid = 1;
    #1;
    exp_req = rn && !rd && (m_out + m_bpc.size() < DEPTH);
    if (chk_en) begin
      chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
      if (rn) chk("req_addr", imem_req_addr, m_pc);
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_bpc.size() > 0});
      if (m_bpc.size() > 0) begin
        chk("if_pc", if_pc, m_bpc[0]);
        chk("if_instr", if_instr, m_bins[0]);
        chk("if_pcplus4", if_pcplus4, m_bpc[0] + 32'd4);
      end
    end
    @(posedge clk);
    if (!rn) begin
      m_pc = RESET_PC; m_out = 0; m_disc = 0;
      m_tags.delete(); m_bpc.delete(); m_bins.delete(); mq_addr.delete(); mq_due.delete();
    end else begin
      rsp  = imem_rsp_valid && m_out > 0;
      pop  = m_bpc.size() > 0 && if_ready && !rd;
      fire = exp_req && imem_req_ready;
      if (rsp) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (rd) begin
        m_tags.delete(); m_bpc.delete(); m_bins.delete();
        if (rsp) m_out--;
        m_disc = m_out;
        m_pc = {rp[31:2], 2'b00};
      end else begin
        if (pop) begin
          void'(m_bpc.pop_front());
          void'(m_bins.pop_front());
        end
        if (rsp) begin
          m_out--;
          if (m_disc > 0) m_disc--;
          else begin
            m_bpc.push_back(m_tags.pop_front());
            m_bins.push_back(imem_rsp_data);
          end
        end
        if (fire) begin
          m_tags.push_back(m_pc);
          mq_addr.push_back(m_pc);
          mq_due.push_back(cyc + 1 + $urandom_range(0, xlat));
          m_out++;
          m_pc = m_pc + 32'd4;
        end
      end
    end
    chk_en = 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, $urandom);
  endtask

  initial begin
    reset = 0; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; if_ready = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    run(12);
    pif = 0; run(6); pif = 100; run(4);
    prsp = 0; run(3); tick(1, 1, 32'h00000103); prsp = 100; run(8);
    pr = 0; run(4); pr = 100; run(3);
    tick(1, 1, 32'hFFFFFFFC); run(6);
    pif = 0; run(6); tick(0, 0, 0); pif = 100; run(4);
    for (int b = 0; b < 30; b++) begin
      pr = $urandom_range(30, 100); pif = $urandom_range(20, 100);
      prsp = $urandom_range(30, 100); xlat = $urandom_range(0, 3);
      for (int i = 0; i < 100; i++)
        tick($urandom % 300 != 0, $urandom % 10 == 0, ($urandom % 4 == 0) ? 32'hFFFFFFF0 + ($urandom % 16) : $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
